game_ctrl: RTL and testbench

Game-flow controller sitting directly downstream of the bean renderer. Each pixel it takes the renderer's `bean` flag and the goose sprite's `goose` flag and counts colliding pixels per frame. At each frame boundary it runs the IDLE/RUN/HIT/OVER state machine. It drives back the `stop` and game-reset signals the renderer consumes, and the running `score` it reads for difficulty scaling.

---
 rtl/game_pkg.sv | 28 ++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/game_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: VGA timing, game tuning values and state encoding.
package game_pkg;

    // Frame timing shared with the VGA timing generator
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    // Default game tuning
    localparam int unsigned HIT_THRESH_DEF    = 4;
    localparam int unsigned SCORE_DIV_DEF     = 6;
    localparam int unsigned FREEZE_FRAMES_DEF = 60;

    // Encoding is visible on the state output, so values are fixed
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHit  = 2'd2,
        StOver = 2'd3
    } game_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for raw buttons plus a rising-edge detector on the OR
// of all synchronized bits.
module btn_sync_edge #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    output logic             rise
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic             any_q;

    // Synchronizer chain and previous value of the combined button level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            any_q   <= |sync2_q;
        end
    end

    assign rise = (|sync2_q) & ~any_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: counts bean/goose collisions per frame and steps the
// IDLE/RUN/HIT/OVER machine at every frame end.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned HIT_THRESH    = HIT_THRESH_DEF,
    parameter int unsigned SCORE_DIV     = SCORE_DIV_DEF,
    parameter int unsigned FREEZE_FRAMES = FREEZE_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        bean,
    input  logic        goose,
    input  logic [1:0]  button,
    output logic        stop,
    output logic        game_rst,
    output logic [31:0] score,
    output logic [31:0] high_score,
    output logic [1:0]  state
);

    localparam int unsigned DivW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int unsigned FrzW = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

    game_state_e      state_q, state_d;
    logic [31:0]      score_q, score_d;
    logic [31:0]      high_q, high_d;
    logic [9:0]       ov_q, ov_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [FrzW-1:0]  frz_q, frz_d;
    logic             pend_q, pend_d;
    logic             stop_q, stop_d;
    logic             grst_q, grst_d;
    logic             rise;
    logic             fe;
    logic             hit_px;
    logic             consume;

    btn_sync_edge #(
        .WIDTH (2)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_in (button),
        .rise   (rise)
    );

    assign fe     = (x == 10'(H_TOTAL - 1)) && (y == 10'(V_TOTAL - 1));
    assign hit_px = bean && goose && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));

    // Next-state: collision counter, FSM, score and press bookkeeping
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        div_d   = div_q;
        frz_d   = frz_q;
        ov_d    = ov_q;
        consume = 1'b0;

        // Frame-end pixel is in blanking, so clearing here loses no count
        if (fe) begin
            ov_d = '0;
        end else if (hit_px && (ov_q != 10'h3FF)) begin
            ov_d = ov_q + 10'd1;
        end

        if (fe) begin
            unique case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        state_d = StRun;
                        score_d = '0;
                        consume = 1'b1;
                    end
                end
                StRun: begin
                    // A hit takes priority over a divider wrap on the same frame
                    if (ov_q >= 10'(HIT_THRESH)) begin
                        state_d = StHit;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else if (div_q == DivW'(SCORE_DIV - 1)) begin
                        div_d   = '0;
                        score_d = sat_inc32(score_q);
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end
                StHit: begin
                    if (frz_q == FrzW'(FREEZE_FRAMES - 1)) begin
                        state_d = StOver;
                    end else begin
                        frz_d = frz_q + FrzW'(1);
                    end
                end
                StOver: begin
                    if (pend_q) begin
                        state_d = StIdle;
                        consume = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d != state_q) begin
            div_d = '0;
            frz_d = '0;
        end

        // A press arriving on the fe cycle survives the consume for the next fe
        pend_d = consume ? rise : (pend_q | rise);
        if (state_q == StHit) begin
            pend_d = 1'b0;
        end

        stop_d = (state_d == StHit) || (state_d == StOver);
        grst_d = (state_d == StIdle);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            score_q <= '0;
            high_q  <= '0;
            ov_q    <= '0;
            div_q   <= '0;
            frz_q   <= '0;
            pend_q  <= 1'b0;
            stop_q  <= 1'b0;
            grst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            ov_q    <= ov_d;
            div_q   <= div_d;
            frz_q   <= frz_d;
            pend_q  <= pend_d;
            stop_q  <= stop_d;
            grst_q  <= grst_d;
        end
    end

    assign state      = state_q;
    assign stop       = stop_q;
    assign game_rst   = grst_q;
    assign score      = score_q;
    assign high_score = high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: frames are compressed to a handful of pixels
// followed by the frame-end pixel; expected outputs go through a queue.
module tb_game_ctrl;

    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bean;
    logic        goose;
    logic [1:0]  button;
    logic        stop;
    logic        game_rst;
    logic [31:0] score;
    logic [31:0] high_score;
    logic [1:0]  state;

    int checks;
    int failures;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        stop;
        logic        grst;
        logic [31:0] score;
        logic [31:0] hs;
    } exp_t;

    exp_t exp_q[$];

    game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .bean       (bean),
        .goose      (goose),
        .button     (button),
        .stop       (stop),
        .game_rst   (game_rst),
        .score      (score),
        .high_score (high_score),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int px, input int py, input logic b, input logic g);
        x     = 10'(px);
        y     = 10'(py);
        bean  = b;
        goose = g;
    endtask

    task automatic push_exp(input string tag, input int st, input logic stp, input logic grst,
                            input logic [31:0] sc, input logic [31:0] hs);
        exp_t e;
        e.tag   = tag;
        e.st    = 2'(st);
        e.stop  = stp;
        e.grst  = grst;
        e.score = sc;
        e.hs    = hs;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty got=0 entries required=1");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (state === e.st) else begin
            failures++;
            $error("FAIL %s state got=%0d required=%0d", e.tag, state, e.st);
        end
        checks++;
        assert (stop === e.stop) else begin
            failures++;
            $error("FAIL %s stop got=%0b required=%0b", e.tag, stop, e.stop);
        end
        checks++;
        assert (game_rst === e.grst) else begin
            failures++;
            $error("FAIL %s game_rst got=%0b required=%0b", e.tag, game_rst, e.grst);
        end
        checks++;
        assert (score === e.score) else begin
            failures++;
            $error("FAIL %s score got=%0h required=%0h", e.tag, score, e.score);
        end
        checks++;
        assert (high_score === e.hs) else begin
            failures++;
            $error("FAIL %s high_score got=%0h required=%0h", e.tag, high_score, e.hs);
        end
    endtask

    // One compressed frame: ncoll colliding pixels at column cx, some decoys,
    // then the frame-end pixel; outputs are checked just after the fe edge.
    task automatic frame(input int ncoll, input int cx, input string tag, input int st,
                         input logic stp, input logic grst, input logic [31:0] sc,
                         input logic [31:0] hs);
        push_exp(tag, st, stp, grst, sc, hs);
        for (int i = 0; i < ncoll; i++) begin
            drive(cx, 20 + i, 1'b1, 1'b1);
            tick();
        end
        drive(100, 30, 1'b1, 1'b0);   // bean only
        tick();
        drive(100, 500, 1'b1, 1'b1);  // vertical blanking
        tick();
        drive(900, 524, 1'b0, 1'b0);  // out-of-range x, not a frame end
        tick();
        drive(799, 600, 1'b0, 1'b0);  // out-of-range y, not a frame end
        tick();
        drive(799, 524, 1'b0, 1'b0);
        tick();
        drive(0, 0, 1'b0, 1'b0);
        pop_check();
    endtask

    task automatic press(input logic [1:0] b);
        drive(5, 5, 1'b0, 1'b0);
        button = b;
        repeat (4) tick();
        button = 2'b00;
        repeat (3) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        button   = 2'b00;
        drive(0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        push_exp("reset", 0, 1'b0, 1'b1, 32'd0, 32'd0);
        pop_check();
        reset = 1'b1;
        tick();

        frame(0, 0, "idle_f1", 0, 1'b0, 1'b1, 32'd0, 32'd0);
        frame(0, 0, "idle_f2", 0, 1'b0, 1'b1, 32'd0, 32'd0);

        press(2'b10);
        frame(0, 0, "start", 1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            frame(0, 0, "run_clean", 1, 1'b0, 1'b0, 32'(k / 6), 32'd0);
        end

        frame(3, 100, "coll3", 1, 1'b0, 1'b0, 32'd2, 32'd0);
        frame(4, 700, "coll_blank", 1, 1'b0, 1'b0, 32'd2, 32'd0);
        for (int k = 0; k < 3; k++) begin
            frame(0, 0, "run_pre_hit", 1, 1'b0, 1'b0, 32'd2, 32'd0);
        end
        // Divider is at its last step here, so this frame would also score
        frame(4, 100, "hit_wrap", 2, 1'b1, 1'b0, 32'd2, 32'd2);

        press(2'b01);
        for (int f = 1; f < 60; f++) begin
            if (f == 30) press(2'b11);
            frame(0, 0, "hit_hold", 2, 1'b1, 1'b0, 32'd2, 32'd2);
        end
        frame(0, 0, "over", 3, 1'b1, 1'b0, 32'd2, 32'd2);
        frame(0, 0, "over_nopress", 3, 1'b1, 1'b0, 32'd2, 32'd2);

        press(2'b10);
        frame(0, 0, "to_idle", 0, 1'b0, 1'b1, 32'd2, 32'd2);
        press(2'b01);
        frame(0, 0, "restart", 1, 1'b0, 1'b0, 32'd0, 32'd2);

        force dut.score_q = 32'hFFFF_FFFF;
        #1;
        release dut.score_q;
        push_exp("preload", 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        pop_check();
        for (int k = 0; k < 6; k++) begin
            frame(0, 0, "sat", 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        end
        frame(5, 50, "hit_max", 2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        push_exp("reset_in_hit", 0, 1'b0, 1'b1, 32'd0, 32'd0);
        pop_check();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
